lfsr_seq_checker: RTL and testbench

- Receiving end of the XOR-feedback (LFSR) counter stream. Samples the counter's output word each valid cycle, locks onto the sequence and predicts each next word.
- Flags and counts mismatches, and drops lock after repeated consecutive misses.
- Sits beside the counter DUT in timing-characterisation builds as a self-checking monitor, so corrupted samples are detected in hardware.

---
 rtl/lfsr_seq_chk_pkg.sv | 22 ++
 rtl/lfsr_step.sv | 15 +
 rtl/lfsr_seq_checker.sv | 124 ++++++++++++
 tb/tb_lfsr_seq_checker.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_seq_chk_pkg.sv
// Shared types and constants for the LFSR sequence checker: FSM states,
// default word width / feedback mask, and a default-width step helper.
package lfsr_seq_chk_pkg;

   typedef enum logic [1:0] {
      HUNT,
      VERIFY,
      LOCKED
   } chk_state_t;

   localparam int                     DEF_WIDTH = 4;
   localparam logic [DEF_WIDTH-1:0]   DEF_TAPS  = 4'b1100;

   // Shift left, feeding the parity of the tapped bits into bit 0.
   function automatic logic [DEF_WIDTH-1:0] lfsr_next(
      input logic [DEF_WIDTH-1:0] cur,
      input logic [DEF_WIDTH-1:0] taps
   );
      return {cur[DEF_WIDTH-2:0], ^(cur & taps)};
   endfunction

endpackage

// File: rtl/lfsr_step.sv
// One combinational XOR-feedback step: next_word is the word that follows
// cur in the sequence defined by TAPS.
module lfsr_step
   import lfsr_seq_chk_pkg::*;
#(
   parameter int               WIDTH = DEF_WIDTH,
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_TAPS)
) (
   input  logic [WIDTH-1:0] cur,
   output logic [WIDTH-1:0] next_word
);

   assign next_word = {cur[WIDTH-2:0], ^(cur & TAPS)};

endmodule

// File: rtl/lfsr_seq_checker.sv
// Monitor for an XOR-feedback counter stream: hunts for a seed, verifies a
// run of predictions, then flywheels and counts mismatches while locked.
// Optional build macro LFSR_SEQ_CHK_STATS_EN adds a word_count output.
module lfsr_seq_checker
   import lfsr_seq_chk_pkg::*;
#(
   parameter int               WIDTH       = DEF_WIDTH,
   parameter logic [WIDTH-1:0] TAPS        = WIDTH'(DEF_TAPS),
   parameter int               LOCK_CNT    = 3,
   parameter int               UNLOCK_ERRS = 2,
   parameter int               ERR_CNT_W   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     data_in,
   input  logic                 data_valid,
   output logic                 locked,
   output logic                 err_pulse,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic [WIDTH-1:0]     expected
`ifdef LFSR_SEQ_CHK_STATS_EN
   ,
   output logic [31:0]          word_count
`endif
);

   localparam int MW = $clog2(LOCK_CNT + 1);
   localparam int SW = $clog2(UNLOCK_ERRS + 1);

   chk_state_t     state;
   logic [MW-1:0]  match_cnt;
   logic [SW-1:0]  miss_cnt;
   logic [MW-1:0]  match_nxt;
   logic [SW-1:0]  miss_nxt;
   logic [WIDTH-1:0] step_cur;
   logic [WIDTH-1:0] step_next;
   logic           is_match;

   // While locked the prediction runs from its own history; otherwise it is
   // seeded from the sample (identical to expected on a VERIFY match).
   assign step_cur  = (state == LOCKED) ? expected : data_in;
   assign is_match  = (data_in == expected);
   assign match_nxt = match_cnt + MW'(1);
   assign miss_nxt  = miss_cnt + SW'(1);

   lfsr_step #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS)
   ) u_step (
      .cur       (step_cur),
      .next_word (step_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= HUNT;
         locked    <= 1'b0;
         err_pulse <= 1'b0;
         err_count <= '0;
         expected  <= '0;
         match_cnt <= '0;
         miss_cnt  <= '0;
`ifdef LFSR_SEQ_CHK_STATS_EN
         word_count <= '0;
`endif
      end else begin
         err_pulse <= 1'b0;
         if (data_valid) begin
            case (state)
               HUNT: begin
                  // The all-zero word is the LFSR lock-up state and cannot seed.
                  if (data_in != '0) begin
                     expected  <= step_next;
                     match_cnt <= '0;
                     state     <= VERIFY;
                  end
               end
               VERIFY: begin
                  expected <= step_next;
                  if (is_match) begin
                     match_cnt <= match_nxt;
                     if (match_nxt == MW'(LOCK_CNT)) begin
                        state    <= LOCKED;
                        locked   <= 1'b1;
                        miss_cnt <= '0;
                     end
                  end else begin
                     match_cnt <= '0;
                     if (data_in == '0) begin
                        state <= HUNT;
                     end
                  end
               end
               LOCKED: begin
                  expected <= step_next;
`ifdef LFSR_SEQ_CHK_STATS_EN
                  if (word_count != '1) begin
                     word_count <= word_count + 32'd1;
                  end
`endif
                  if (is_match) begin
                     miss_cnt <= '0;
                  end else begin
                     err_pulse <= 1'b1;
                     if (err_count != '1) begin
                        err_count <= err_count + ERR_CNT_W'(1);
                     end
                     if (miss_nxt == SW'(UNLOCK_ERRS)) begin
                        state     <= HUNT;
                        locked    <= 1'b0;
                        match_cnt <= '0;
                        miss_cnt  <= '0;
                     end else begin
                        miss_cnt <= miss_nxt;
                     end
                  end
               end
               default: state <= HUNT;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Directed bench for lfsr_seq_checker: default x^4+x^3+1 sequence
// 1,2,4,9,3,6,D,A,5,B,7,F,E,C,8 with a second ERR_CNT_W=2 instance.
module tb_lfsr_seq_checker;

   logic       clk;
   logic       rst;
   logic [3:0] data_in;
   logic       data_valid;

   logic       locked;
   logic       err_pulse;
   logic [7:0] err_count;
   logic [3:0] exp_word;

   logic       locked_sat;
   logic       pulse_sat;
   logic [1:0] err_count_sat;
   logic [3:0] exp_sat;

`ifdef LFSR_SEQ_CHK_STATS_EN
   logic [31:0] word_count;
   logic [31:0] word_count_sat;
`endif

   int checks = 0;
   int errors = 0;

   lfsr_seq_checker dut (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .data_valid (data_valid),
      .locked     (locked),
      .err_pulse  (err_pulse),
      .err_count  (err_count),
      .expected   (exp_word)
`ifdef LFSR_SEQ_CHK_STATS_EN
      ,
      .word_count (word_count)
`endif
   );

   lfsr_seq_checker #(.ERR_CNT_W(2)) dut_sat (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .data_valid (data_valid),
      .locked     (locked_sat),
      .err_pulse  (pulse_sat),
      .err_count  (err_count_sat),
      .expected   (exp_sat)
`ifdef LFSR_SEQ_CHK_STATS_EN
      ,
      .word_count (word_count_sat)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive one cycle of input, then settle just after the rising edge.
   task automatic applyStimulus(input logic v, input logic [3:0] d);
      @(negedge clk);
      data_valid = v;
      data_in    = d;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      applyStimulus(1'b1, 4'h5);
      rst = 1'b0;
      checks++;
      if (locked !== 1'b0 || err_pulse !== 1'b0 || err_count !== 8'd0 || exp_word !== 4'h0
          || err_count_sat !== 2'd0 || locked_sat !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset: locked=%b pulse=%b errc=%0d exp=%h satc=%0d, want 0,0,0,0,0",
                  locked, err_pulse, err_count, exp_word, err_count_sat);
      end
   endtask

   task automatic test_lock();
      logic [3:0] din [6] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6};
      logic [3:0] exw [6] = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD};
      logic       lk  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, din[i]);
         checks++;
         if (locked !== lk[i] || exp_word !== exw[i] || err_pulse !== 1'b0 || err_count !== 8'd0) begin
            errors++;
            $display("[TB] FAIL lock[%0d]: locked=%b exp=%h pulse=%b errc=%0d, want %b,%h,0,0",
                     i, locked, exp_word, err_pulse, err_count, lk[i], exw[i]);
         end
      end
   endtask

   task automatic test_single_error();
      logic [3:0] din [3] = '{4'hD, 4'h0, 4'h5};
      logic [3:0] exw [3] = '{4'hA, 4'h5, 4'hB};
      logic       pls [3] = '{1'b0, 1'b1, 1'b0};
      logic [7:0] erc [3] = '{8'd0, 8'd1, 8'd1};
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, din[i]);
         checks++;
         if (locked !== 1'b1 || exp_word !== exw[i] || err_pulse !== pls[i] || err_count !== erc[i]) begin
            errors++;
            $display("[TB] FAIL single_err[%0d]: locked=%b exp=%h pulse=%b errc=%0d, want 1,%h,%b,%0d",
                     i, locked, exp_word, err_pulse, err_count, exw[i], pls[i], erc[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] din [6] = '{4'h0, 4'h0, 4'h7, 4'hF, 4'hE, 4'hC};
      logic [3:0] exw [6] = '{4'h7, 4'hF, 4'hF, 4'hE, 4'hC, 4'h8};
      logic       lk  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic       pls [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [7:0] erc [6] = '{8'd2, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3};
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, din[i]);
         checks++;
         if (locked !== lk[i] || exp_word !== exw[i] || err_pulse !== pls[i] || err_count !== erc[i]) begin
            errors++;
            $display("[TB] FAIL unlock[%0d]: locked=%b exp=%h pulse=%b errc=%0d, want %b,%h,%b,%0d",
                     i, locked, exp_word, err_pulse, err_count, lk[i], exw[i], pls[i], erc[i]);
         end
      end
   endtask

   task automatic test_zero_wrap();
      logic       vld [12] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
      logic [3:0] din [12] = '{4'h0, 4'h7, 4'h0, 4'h7, 4'hC, 4'h7, 4'h8, 4'h3, 4'h1, 4'h5, 4'h2, 4'h9};
      logic [3:0] exw [12] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h8, 4'h1, 4'h1, 4'h2, 4'h2, 4'h4, 4'h4};
      logic       lk  [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
      rst = 1'b1;
      applyStimulus(1'b0, 4'h0);
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         applyStimulus(vld[i], din[i]);
         checks++;
         if (locked !== lk[i] || exp_word !== exw[i] || err_pulse !== 1'b0 || err_count !== 8'd0) begin
            errors++;
            $display("[TB] FAIL zero_wrap[%0d]: locked=%b exp=%h pulse=%b errc=%0d, want %b,%h,0,0",
                     i, locked, exp_word, err_pulse, err_count, lk[i], exw[i]);
         end
      end
   endtask

   task automatic test_saturation();
      logic [3:0] din [10] = '{4'h0, 4'h9, 4'h0, 4'h6, 4'h0, 4'hA, 4'h0, 4'hB, 4'h0, 4'hF};
      logic [3:0] exw [10] = '{4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7, 4'hF, 4'hE};
      logic       pls [10] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
      logic [7:0] erc [10] = '{8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3, 8'd4, 8'd4, 8'd5, 8'd5};
      logic [1:0] src [10] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, din[i]);
         checks++;
         if (locked !== 1'b1 || exp_word !== exw[i] || err_pulse !== pls[i] || err_count !== erc[i]
             || err_count_sat !== src[i] || locked_sat !== 1'b1 || pulse_sat !== pls[i] || exp_sat !== exw[i]) begin
            errors++;
            $display("[TB] FAIL saturate[%0d]: locked=%b exp=%h pulse=%b errc=%0d satc=%0d, want 1,%h,%b,%0d,%0d",
                     i, locked, exp_word, err_pulse, err_count, err_count_sat, exw[i], pls[i], erc[i], src[i]);
         end
      end
`ifdef LFSR_SEQ_CHK_STATS_EN
      checks++;
      if (word_count !== 32'd10 || word_count_sat !== 32'd10) begin
         errors++;
         $display("[TB] FAIL word_count: got %0d/%0d, want 10", word_count, word_count_sat);
      end
`endif
   endtask

   task automatic test_reset_locked();
      rst = 1'b1;
      applyStimulus(1'b1, 4'hE);
      rst = 1'b0;
      checks++;
      if (locked !== 1'b0 || err_pulse !== 1'b0 || err_count !== 8'd0 || exp_word !== 4'h0
          || err_count_sat !== 2'd0) begin
         errors++;
         $display("[TB] FAIL reset_locked: locked=%b pulse=%b errc=%0d exp=%h satc=%0d, want 0,0,0,0,0",
                  locked, err_pulse, err_count, exp_word, err_count_sat);
      end
`ifdef LFSR_SEQ_CHK_STATS_EN
      checks++;
      if (word_count !== 32'd0) begin
         errors++;
         $display("[TB] FAIL word_count_reset: got %0d, want 0", word_count);
      end
`endif
      applyStimulus(1'b1, 4'h0);
      checks++;
      if (locked !== 1'b0 || exp_word !== 4'h0 || err_count !== 8'd0) begin
         errors++;
         $display("[TB] FAIL hunt_zero: locked=%b exp=%h errc=%0d, want 0,0,0", locked, exp_word, err_count);
      end
      applyStimulus(1'b1, 4'hE);
      checks++;
      if (locked !== 1'b0 || exp_word !== 4'hC || err_pulse !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reseed: locked=%b exp=%h pulse=%b, want 0,c,0", locked, exp_word, err_pulse);
      end
   endtask

   initial begin
      rst        = 1'b1;
      data_valid = 1'b0;
      data_in    = 4'h0;
      test_reset();
      test_lock();
      test_single_error();
      test_back_to_back();
      test_zero_wrap();
      test_saturation();
      test_reset_locked();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
